// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: register map, FSM states and STATUS layout shared by rst_seq_gen
package rst_seq_pkg;
  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_SWRST  = 5'd2;
  localparam logic [4:0] ADDR_DELAY0 = 5'd3;
  localparam int CTRL_START  = 0;
  localparam int CTRL_BYPASS = 1;
  localparam int ST_DONE = 0;
  localparam int ST_LOCK = 1;
  localparam int ST_FSM  = 2;
  localparam int ST_RSTN = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_e;
endpackage

// File: rtl/rst_seq_swpulse.sv
// rst_seq_swpulse: per-channel software reset pulse down-counter
module rst_seq_swpulse #(
  parameter int SW_PULSE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  input  logic clr_i,
  input  logic trig_i,
  output logic active_o
);
  localparam int W = $clog2(SW_PULSE + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // reload on trigger (restarting any running pulse), otherwise count down to zero
  always_comb begin
    cnt_d = hold_i ? cnt_q : clr_i ? '0 : trig_i ? W'(SW_PULSE) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    active_o = cnt_q != '0;
  end
  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: lock-qualified, ordered release of NUM_CH reset domains with leading clock enables
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 12,
  parameter int CLK_EN_LEAD   = 4,
  parameter int LOCK_LOSS_RST = 1,
  parameter int SW_PULSE      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              testmode_i,
  input  logic              lock_i,
  input  logic              cfg_req_i,
  input  logic              cfg_wrn_i,
  input  logic [4:0]        cfg_add_i,
  input  logic [31:0]       cfg_data_i,
  output logic              cfg_ack_o,
  output logic [31:0]       cfg_r_data_o,
  output logic [NUM_CH-1:0] rstn_o,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic              done_o
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cur_q, cur_d, thr;
  logic [CNT_W-1:0] delay_q [NUM_CH];
  logic [CNT_W-1:0] delay_d [NUM_CH];
  logic [NUM_CH-1:0] rstn_q, rstn_d, en_q, en_d, en_live, sw_act, sw_trig;
  logic lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d, bypass_q, bypass_d, ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d, rd_val, status;
  logic acc, we, start, lock_ok, last, unused_ok;

  assign unused_ok = ^cfg_data_i;
  assign cfg_ack_o = ack_q;
  assign cfg_r_data_o = rdata_q;

  // config port: one-cycle ack, register writes on the ack edge, registered read data
  always_comb begin
    acc = cfg_req_i & ~ack_q;
    we = acc & ~cfg_wrn_i;
    ack_d = acc;
    start = we & (cfg_add_i == ADDR_CTRL) & cfg_data_i[CTRL_START];
    bypass_d = (we & (cfg_add_i == ADDR_CTRL)) ? cfg_data_i[CTRL_BYPASS] : bypass_q;
    sw_trig = (we & (cfg_add_i == ADDR_SWRST) & (state_q == RUN)) ? cfg_data_i[NUM_CH-1:0] : '0;
    status = '0;
    status[ST_DONE] = done_o;
    status[ST_LOCK] = lock_s2_q;
    status[ST_FSM +: 3] = state_q;
    status[ST_RSTN +: NUM_CH] = rstn_o;
    rd_val = (cfg_add_i == ADDR_CTRL) ? {30'd0, bypass_q, 1'b0} : (cfg_add_i == ADDR_STATUS) ? status : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      delay_d[i] = (we && cfg_add_i == ADDR_DELAY0 + 5'(i)) ? cfg_data_i[CNT_W-1:0] : delay_q[i];
      if (cfg_add_i == ADDR_DELAY0 + 5'(i)) rd_val = 32'(delay_q[i]);
    end
    rdata_d = (acc & cfg_wrn_i) ? rd_val : '0;
    lock_s1_d = lock_i;
    lock_s2_d = lock_s1_q;
  end

  // sequencing FSM: per-channel delay countdown, in-order release and lock-loss restart
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    rstn_d = rstn_q;
    en_d = en_q;
    lock_ok = lock_s2_q | bypass_q;
    last = (cur_q == '0) || (cnt_q == cur_q - 1'b1);
    thr = (cur_q > CNT_W'(CLK_EN_LEAD)) ? cur_q - CNT_W'(CLK_EN_LEAD) : '0;
    nxt = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    if (testmode_i) begin
      state_d = state_q;
    end else if (LOCK_LOSS_RST != 0 && !lock_ok && (state_q == RELEASE || state_q == RUN)) begin
      state_d = WAIT_LOCK;
      rstn_d = '0;
      en_d = '0;
    end else if (state_q == IDLE) begin
      if (start) state_d = WAIT_LOCK;
    end else if (state_q == WAIT_LOCK) begin
      if (lock_ok) begin
        state_d = RELEASE;
        ch_d = '0;
        cnt_d = '0;
        cur_d = delay_d[0];
      end
    end else if (state_q == RELEASE) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        rstn_d[ch_q] = 1'b1;
        en_d[ch_q] = 1'b1;
        ch_d = nxt;
        cnt_d = '0;
        cur_d = delay_d[nxt];
        if (ch_q == CH_W'(NUM_CH - 1)) state_d = RUN;
      end
    end
  end

  // outputs: the active channel's enable leads its release; testmode forces everything open
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      en_live[i] = (state_q == RELEASE) && (ch_q == CH_W'(i)) && (cur_q != '0) && (cnt_q >= thr);
    rstn_o = testmode_i ? {NUM_CH{~rst_i}} : rstn_q & ~sw_act;
    clk_en_o = testmode_i ? '1 : en_q | en_live;
    done_o = state_q == RUN;
  end

  // state, config and lock synchronizer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
      rstn_q <= '0;
      en_q <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      bypass_q <= 1'b0;
      ack_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_CH; i++) delay_q[i] <= CNT_W'(16 * (i + 1));
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      rstn_q <= rstn_d;
      en_q <= en_d;
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
      bypass_q <= bypass_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
      delay_q <= delay_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_sw
    rst_seq_swpulse #(.SW_PULSE(SW_PULSE)) u_sw (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .hold_i(testmode_i),
      .clr_i(state_q != RUN),
      .trig_i(sw_trig[c]),
      .active_o(sw_act[c])
    );
  end
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: randomized bench against a release-schedule reference model
module tb_rst_seq_gen;
  localparam int N = 4, LEAD = 4, PULSE = 16;
  logic clk = 1'b0, rst, testmode, lock, req, wrn, ack, done;
  logic [4:0] addr;
  logic [31:0] wdata, rdata;
  logic [N-1:0] rstn, clk_en;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, ph = 0;
  int m_delay [N];
  int r_t [N];
  int e_t [N];
  int pend [N];
  bit m_bypass, m_l1, m_l2, m_ack;
  logic [31:0] m_rdata;
  logic [N-1:0] x_rstn, x_en;
  bit x_done;

  always #5 clk = ~clk;

  rst_seq_gen dut (
    .clk_i(clk), .rst_i(rst), .testmode_i(testmode), .lock_i(lock),
    .cfg_req_i(req), .cfg_wrn_i(wrn), .cfg_add_i(addr), .cfg_data_i(wdata),
    .cfg_ack_o(ack), .cfg_r_data_o(rdata), .rstn_o(rstn), .clk_en_o(clk_en), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] read_model(input logic [4:0] a, input logic [N-1:0] prev_rstn);
    if (a == 0) return {30'd0, m_bypass, 1'b0};
    if (a == 1) return (32'(prev_rstn) << 8) | (32'(ph) << 2) | (32'(m_l2) << 1) | 32'(ph == 3);
    if (a >= 3 && a < 3 + N) return 32'(m_delay[a - 3]);
    return 0;
  endfunction

  task automatic tick();
    bit ok_prev, acc;
    int s, d;
    logic [N-1:0] prev_rstn;
    @(posedge clk);
    cyc++;
    prev_rstn = x_rstn;
    ok_prev = m_l2 | m_bypass;
    acc = req && !m_ack;
    if (rst) begin
      ph = 0; m_bypass = 0; m_l1 = 0; m_l2 = 0; m_ack = 0; m_rdata = 0;
      for (int k = 0; k < N; k++) begin m_delay[k] = 16 * (k + 1); pend[k] = 0; end
    end else begin
      m_rdata = (acc && wrn) ? read_model(addr, prev_rstn) : 0;
      if (acc && !wrn && addr == 0) m_bypass = wdata[1];
      if (acc && !wrn && addr >= 3 && addr < 3 + N) m_delay[addr - 3] = int'(wdata[11:0]);
      if (!testmode) begin
        if (ph >= 2 && !ok_prev) begin
          ph = 1;
          for (int k = 0; k < N; k++) pend[k] = 0;
        end else if (ph == 0 && acc && !wrn && addr == 0 && wdata[0]) ph = 1;
        else if (ph == 1 && ok_prev) begin
          ph = 2;
          s = cyc;
          for (int k = 0; k < N; k++) begin
            d = m_delay[k];
            r_t[k] = s + (d == 0 ? 1 : d);
            e_t[k] = d == 0 ? r_t[k] : s + (d > LEAD ? d - LEAD : 0);
            s = r_t[k];
          end
        end else if (ph == 2 && cyc == r_t[N-1]) ph = 3;
        else if (ph == 3 && acc && !wrn && addr == 2)
          for (int k = 0; k < N; k++) if (wdata[k]) pend[k] = cyc + PULSE;
      end
      m_ack = acc;
      m_l2 = m_l1;
      m_l1 = lock;
    end
    x_done = ph == 3;
    for (int k = 0; k < N; k++) begin
      x_rstn[k] = ph == 2 ? cyc >= r_t[k] : ph == 3 ? cyc >= pend[k] : 1'b0;
      x_en[k] = ph == 2 ? cyc >= e_t[k] : ph == 3;
    end
    if (testmode) begin x_rstn = {N{~rst}}; x_en = '1; end
    @(negedge clk);
    chk("rstn", 32'(rstn), 32'(x_rstn));
    chk("clk_en", 32'(clk_en), 32'(x_en));
    chk("done", 32'(done), 32'(x_done));
    chk("ack", 32'(ack), 32'(m_ack));
    if (m_ack) chk("rdata", rdata, m_rdata);
  endtask

  task automatic cfg(input bit w, input logic [4:0] a, input logic [31:0] d);
    int g = 0;
    req = 1; wrn = w; addr = a; wdata = d;
    do begin tick(); g++; end while (!m_ack && g < 4);
    req = 0;
  endtask

  task automatic run_until(input int target, input int limit);
    int n = 0;
    while (ph != target && n < limit) begin tick(); n++; end
  endtask

  initial begin
    bit b;
    int lock_at, r;
    rst = 1; testmode = 0; lock = 0; req = 0; wrn = 0; addr = 0; wdata = 0;
    repeat (3) tick();
    rst = 0;
    for (int k = 0; k < N; k++) cfg(1, 5'(3 + k), 0);
    cfg(0, 0, 1);
    repeat (10) tick();
    lock = 1;
    run_until(2, 20);
    cfg(1, 1, 0);
    req = 1; wrn = 1; addr = 1;
    repeat (5) tick();
    req = 0;
    cfg(1, 31, 0);
    run_until(3, 400);
    repeat (3) tick();
    cfg(0, 2, 5);
    repeat (7) tick();
    cfg(0, 2, 1);
    repeat (30) tick();
    lock = 0;
    repeat (6) tick();
    lock = 1;
    run_until(3, 400);
    repeat (2) tick();
    lock = 0; rst = 1; tick(); rst = 0;
    cfg(0, 4, 0);
    cfg(0, 5, 2);
    cfg(0, 0, 3);
    run_until(3, 300);
    repeat (2) tick();
    for (int it = 0; it < 6; it++) begin
      rst = 1; lock = 0; tick(); rst = 0;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 1) == 1)
          cfg(0, 5'(3 + k), $urandom_range(0, 1) == 1 ? $urandom_range(0, 6) : $urandom_range(7, 40));
      b = $urandom_range(0, 3) == 0;
      cfg(0, 0, b ? 3 : 1);
      lock_at = $urandom_range(0, 12);
      for (int c = 0; c < 350; c++) begin
        if (c >= lock_at && (lock ? $urandom_range(0, 79) == 0 : $urandom_range(0, 5) == 0)) lock = ~lock;
        r = $urandom_range(0, 29);
        if (r == 0) cfg(1, 5'($urandom_range(0, 31)), 0);
        else if (r == 1) cfg(0, 2, $urandom_range(0, 15));
        else if (r == 2 && $urandom_range(0, 3) == 0) cfg(0, 0, $urandom_range(1, 3));
        else tick();
      end
    end
    rst = 1; lock = 0; tick(); rst = 0;
    cfg(0, 3, 9);
    cfg(0, 6, 1);
    cfg(0, 0, 3);
    run_until(2, 20);
    repeat (20) tick();
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < N; k++) cfg(1, 5'(3 + k), 0);
    testmode = 1;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0; testmode = 0;
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
